// File: rtl/beamformer_pkg.sv
// Types and constants shared by the beamformer sequencer and the beamformer datapath.
// The slice_state encoding is defined only here.
package beamformer_pkg;

    localparam int FILT_ADDR_W = 11;
    localparam int SUM_ADDR_W  = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_READ,
        ST_DRAIN,
        ST_DUMP
    } seq_state_e;

    typedef enum logic [1:0] {
        SLICE_IDLE = 2'd0,
        SLICE1     = 2'd1,
        SLICE2     = 2'd2,
        SLICE3     = 2'd3
    } slice_e;

    // Issue phase 0/1/2 selects bits [31:0]/[63:32]/[95:64] of the stored word.
    function automatic slice_e slice_of_phase(input logic [1:0] phase);
        return slice_e'(phase + 2'd1);
    endfunction

endpackage

// File: rtl/slice_delay_line.sv
// Fixed-depth shift register that aligns control tags with a RAM read latency.
module slice_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // NOTE: the stages are reset, so an aborted frame leaves no stale tag in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/beamformer_sequencer.sv
// Frame sequencer for the BRAM beamformer: capture filter words, replay them as
// three slices, drain the delay-and-sum pipeline, then stream the summed outputs.
module beamformer_sequencer
    import beamformer_pkg::*;
#(
    parameter int NUM_SAMPLES  = 1024,
    parameter int NUM_OUT      = 1024,
    parameter int RD_LAT       = 2,
    parameter int SUM_RD_LAT   = 2,
    parameter int DRAIN_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   filt_valid,
    input  logic                   dump_ready,
    output logic [FILT_ADDR_W-1:0] readin_address,
    output logic                   filter_bram_output_write_en,
    output logic                   output_read_en,
    output logic                   startbeamformer,
    output logic [1:0]             slice_state,
    output logic [15:0]            sample_index,
    output logic [SUM_ADDR_W-1:0]  sumout_address,
    output logic                   sumouten,
    output logic                   dump_valid,
    output logic                   busy,
    output logic                   done
);

    localparam logic [11:0] LAST_SAMPLE = 12'(NUM_SAMPLES - 1);
    localparam logic [10:0] OUT_COUNT   = 11'(NUM_OUT);
    localparam logic [10:0] LAST_OUT    = 11'(NUM_OUT - 1);
    localparam logic [15:0] DRAIN_LAST  = 16'(RD_LAT + DRAIN_CYCLES - 1);

    seq_state_e  state_q;
    logic [11:0] addr_q;
    logic [1:0]  phase_q;
    logic [15:0] drain_q;
    logic [10:0] issued_q;
    logic [10:0] recv_q;
    logic [15:0] sidx_q;
    logic        done_q;

    logic        issuing;
    logic        dump_issue;
    logic        dump_valid_d;
    logic [2:0]  slice_in;
    logic [2:0]  slice_out;

    assign issuing    = (state_q == ST_READ);
    assign slice_in   = issuing ? {slice_of_phase(phase_q), 1'b1} : {SLICE_IDLE, 1'b0};
    assign dump_issue = (state_q == ST_DUMP) && dump_ready && (issued_q < OUT_COUNT);

    slice_delay_line #(.WIDTH(3), .DEPTH(RD_LAT)) u_slice_dl (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (slice_in),
        .q_o   (slice_out)
    );

    slice_delay_line #(.WIDTH(1), .DEPTH(SUM_RD_LAT)) u_dump_dl (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (dump_issue),
        .q_o   (dump_valid_d)
    );

    // NOTE: write enable and sumouten follow their handshake inputs in the same
    // cycle, so a source or sink stall takes effect without a cycle of slip.
    assign filter_bram_output_write_en = (state_q == ST_FILL) && filt_valid;
    assign readin_address  = (state_q == ST_FILL || issuing) ? addr_q[FILT_ADDR_W-1:0] : '0;
    assign output_read_en  = issuing;
    assign startbeamformer = issuing || (state_q == ST_DRAIN);
    assign slice_state     = slice_out[2:1];
    assign sample_index    = sidx_q;
    assign sumout_address  = (state_q == ST_DUMP) ? issued_q[SUM_ADDR_W-1:0] : '0;
    assign sumouten        = dump_issue;
    assign dump_valid      = dump_valid_d;
    assign busy            = (state_q != ST_IDLE);
    assign done            = done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            phase_q  <= '0;
            drain_q  <= '0;
            issued_q <= '0;
            recv_q   <= '0;
            sidx_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Default index advance; a frame-boundary clear below overrides it.
            if (slice_out[0]) sidx_q <= sidx_q + 16'd1;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q  <= ST_FILL;
                        addr_q   <= '0;
                        phase_q  <= '0;
                        drain_q  <= '0;
                        issued_q <= '0;
                        recv_q   <= '0;
                        sidx_q   <= '0;
                    end
                end
                ST_FILL: begin
                    if (filt_valid) begin
                        if (addr_q == LAST_SAMPLE) begin
                            state_q <= ST_READ;
                            addr_q  <= '0;
                        end else begin
                            addr_q <= addr_q + 12'd1;
                        end
                    end
                end
                ST_READ: begin
                    if (phase_q == 2'd2) begin
                        phase_q <= '0;
                        if (addr_q == LAST_SAMPLE) begin
                            state_q <= ST_DRAIN;
                            drain_q <= '0;
                        end else begin
                            addr_q <= addr_q + 12'd1;
                        end
                    end else begin
                        phase_q <= phase_q + 2'd1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == DRAIN_LAST) state_q <= ST_DUMP;
                    else                       drain_q <= drain_q + 16'd1;
                end
                ST_DUMP: begin
                    if (dump_issue) issued_q <= issued_q + 11'd1;
                    if (dump_valid_d) begin
                        if (recv_q == LAST_OUT) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                            sidx_q  <= '0;
                        end else begin
                            recv_q <= recv_q + 11'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_beamformer_sequencer.sv
// Scoreboard bench for beamformer_sequencer: slice and dump expectations are queued
// at frame start and retired as the sequencer emits them.
module tb_beamformer_sequencer;

    localparam int NS  = 4;
    localparam int NO  = 4;
    localparam int RL  = 2;
    localparam int SRL = 2;
    localparam int DC  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        filt_valid = 1'b0;
    logic        dump_ready = 1'b0;
    logic [10:0] readin_address;
    logic        filter_bram_output_write_en;
    logic        output_read_en;
    logic        startbeamformer;
    logic [1:0]  slice_state;
    logic [15:0] sample_index;
    logic [9:0]  sumout_address;
    logic        sumouten;
    logic        dump_valid;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    beamformer_sequencer #(
        .NUM_SAMPLES (NS),
        .NUM_OUT     (NO),
        .RD_LAT      (RL),
        .SUM_RD_LAT  (SRL),
        .DRAIN_CYCLES(DC)
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .start                      (start),
        .filt_valid                 (filt_valid),
        .dump_ready                 (dump_ready),
        .readin_address             (readin_address),
        .filter_bram_output_write_en(filter_bram_output_write_en),
        .output_read_en             (output_read_en),
        .startbeamformer            (startbeamformer),
        .slice_state                (slice_state),
        .sample_index               (sample_index),
        .sumout_address             (sumout_address),
        .sumouten                   (sumouten),
        .dump_valid                 (dump_valid),
        .busy                       (busy),
        .done                       (done)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Summed-output RAM model: q returns the address presented SRL cycles earlier.
    logic [9:0] ram_pipe [SRL];
    always @(posedge clk) begin
        ram_pipe[0] <= sumout_address;
        for (int i = 1; i < SRL; i++) ram_pipe[i] <= ram_pipe[i-1];
    end

    int   slice_exp_q[$];
    int   dump_exp_q[$];
    int   read_entry = 0;
    int   next_idx = 0;
    int   done_seen = 0;
    logic ore_prev = 1'b0;
    logic first_slice = 1'b0;

    always @(negedge clk) begin : monitor
        int e;
        if (rst) begin
            if (output_read_en && !ore_prev) begin
                read_entry  = cyc;
                first_slice = 1'b1;
            end
            ore_prev = output_read_en;
            if (slice_state != 2'd0) begin
                if (first_slice) begin
                    check("slice_latency", cyc - read_entry, RL);
                    first_slice = 1'b0;
                end
                if (slice_exp_q.size() == 0) begin
                    check("slice_extra", 1, 0);
                end else begin
                    e = slice_exp_q.pop_front();
                    check("slice_state", slice_state, e >> 16);
                    check("sample_index", sample_index, e & 'hffff);
                end
                next_idx++;
            end else if (busy) begin
                check("index_hold", sample_index, next_idx);
            end
            if (dump_valid) begin
                if (dump_exp_q.size() == 0) begin
                    check("dump_extra", 1, 0);
                end else begin
                    e = dump_exp_q.pop_front();
                    check("dump_addr", ram_pipe[SRL-1], e);
                end
            end
            if (done) done_seen++;
        end else begin
            ore_prev    = 1'b0;
            first_slice = 1'b0;
        end
    end

    task automatic run_frame(input logic [15:0] pat, input int plen, input bit stall,
                             input bit spurious, input int abort_idx);
        int writes;
        int c;
        int sb_cnt;
        int issued;
        int stall_left;
        int done0;
        done0    = done_seen;
        next_idx = 0;
        for (int k = 0; k < 3 * NS; k++) slice_exp_q.push_back((((k % 3) + 1) << 16) | k);
        for (int a = 0; a < NO; a++) dump_exp_q.push_back(a);
        dump_ready = 1'b1;

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        writes = 0;
        c = 0;
        while (writes < NS && c < 100) begin
            filt_valid = pat[c % plen];
            #1;
            check("wr_en", filter_bram_output_write_en, filt_valid);
            if (filt_valid) begin
                check("wr_addr", readin_address, writes);
                writes++;
            end
            c++;
            @(negedge clk);
        end
        check("fill_count", writes, NS);
        filt_valid = 1'b1;
        #1;
        check("extra_sample", filter_bram_output_write_en, 0);
        check("read_entry", output_read_en, 1);

        if (abort_idx >= 0) begin
            for (int k = 0; k < 100 && sample_index != 16'(abort_idx); k++) begin
                @(negedge clk); filt_valid = 1'b0; #1;
            end
            check("abort_reach", sample_index, abort_idx);
            rst = 1'b0;
            #1;
            check("abort_outputs",
                  {readin_address, filter_bram_output_write_en, output_read_en, startbeamformer,
                   slice_state, sample_index, sumout_address, sumouten, dump_valid, busy, done}, 0);
            repeat (3) @(negedge clk);
            rst = 1'b1;
            slice_exp_q.delete();
            dump_exp_q.delete();
            repeat (3) @(negedge clk);
            #1;
            check("abort_busy", busy, 0);
            check("abort_no_done", done_seen - done0, 0);
            return;
        end

        sb_cnt = 0;
        c = 0;
        do begin
            @(negedge clk);
            filt_valid = 1'b0;
            start = spurious && (sb_cnt == 1);
            #1;
            if (!output_read_en && startbeamformer) sb_cnt++;
            c++;
        end while (!(sb_cnt > 0 && !startbeamformer) && c < 200);
        start = 1'b0;
        check("drain_len", sb_cnt, RL + DC);

        issued = 0;
        stall_left = stall ? 3 : 0;
        for (int k = 0; k < 200; k++) begin
            if (done) break;
            if (sumouten) issued++;
            @(negedge clk);
            dump_ready = !(issued == 2 && stall_left > 0);
            #1;
            if (!dump_ready) begin
                stall_left--;
                check("stall_en", sumouten, 0);
                check("stall_addr", sumout_address, issued);
            end
        end
        dump_ready = 1'b1;
        check("done_seen", done, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            check("idle_busy", busy, 0);
        end
        check("done_count", done_seen - done0, 1);
        check("slice_left", slice_exp_q.size(), 0);
        check("dump_left", dump_exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b1;
        filt_valid = 1'b1;
        dump_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            check("reset_outputs",
                  {readin_address, filter_bram_output_write_en, output_read_en, startbeamformer,
                   slice_state, sample_index, sumout_address, sumouten, dump_valid, busy, done}, 0);
        end
        start = 1'b0;
        filt_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        check("idle_after_reset", busy, 0);

        run_frame(16'hffff, 1, 1'b0, 1'b0, -1);
        run_frame(16'h0059, 7, 1'b1, 1'b0, -1);
        run_frame(16'hffff, 1, 1'b0, 1'b0, 5);
        run_frame(16'hffff, 1, 1'b0, 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
